// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller around an external 1-cycle-read dual-port RAM.
// A 2-entry output buffer absorbs read latency so streaming runs bubble-free.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  localparam logic [ADDR_WIDTH:0] L_DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_inflight;
  logic [1:0]            r_ob_cnt;
  logic [DATA_WIDTH-1:0] r_ob0;
  logic [DATA_WIDTH-1:0] r_ob1;
  logic                  r_m_valid;

  logic                  w_wr;
  logic                  w_pop;
  logic                  w_issue;
  logic [1:0]            w_occ;
  logic [1:0]            w_ob_cnt_nx;
  logic [DATA_WIDTH-1:0] w_ob0_nx;
  logic [DATA_WIDTH-1:0] w_ob1_nx;
  logic [ADDR_WIDTH:0]   w_ram_cnt_nx;

  assign s_ready = rst_n && (r_ram_cnt < L_DEPTH);
  assign w_wr    = s_valid && s_ready;
  assign w_pop   = r_m_valid && m_ready;

  // Buffer slots still committed next cycle; never exceeds 2.
  assign w_occ   = r_ob_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = (r_ram_cnt != '0) && (w_occ < 2'd2);

  assign ram_we_a   = w_wr;
  assign ram_addr_a = r_wr_ptr;
  assign ram_din_a  = s_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = r_rd_ptr;

  assign m_valid = r_m_valid;
  assign m_data  = r_ob0;
  assign count   = {1'b0, r_ram_cnt}
                 + {{(ADDR_WIDTH+1){1'b0}}, r_inflight}
                 + {{ADDR_WIDTH{1'b0}}, r_ob_cnt};
  assign full    = !s_ready;
  assign empty   = (count == '0);

  always_comb begin
    w_ram_cnt_nx = r_ram_cnt;
    unique case ({w_wr, w_issue})
      2'b10:   w_ram_cnt_nx = r_ram_cnt + (ADDR_WIDTH+1)'(1);
      2'b01:   w_ram_cnt_nx = r_ram_cnt - (ADDR_WIDTH+1)'(1);
      default: w_ram_cnt_nx = r_ram_cnt;
    endcase
  end

  always_comb begin
    w_ob0_nx    = r_ob0;
    w_ob1_nx    = r_ob1;
    w_ob_cnt_nx = r_ob_cnt;
    unique case ({r_inflight, w_pop})
      2'b11: begin
        if (r_ob_cnt == 2'd2) begin
          w_ob0_nx = r_ob1;
          w_ob1_nx = ram_dout_b;
        end else begin
          w_ob0_nx = ram_dout_b;
        end
      end
      2'b10: begin
        if (r_ob_cnt == 2'd0) w_ob0_nx = ram_dout_b;
        else                  w_ob1_nx = ram_dout_b;
        w_ob_cnt_nx = r_ob_cnt + 2'd1;
      end
      2'b01: begin
        w_ob0_nx    = r_ob1;
        w_ob_cnt_nx = r_ob_cnt - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_ob_cnt   <= '0;
      r_ob0      <= '0;
      r_ob1      <= '0;
      r_m_valid  <= 1'b0;
    end else begin
      if (w_wr)    r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_ram_cnt  <= w_ram_cnt_nx;
      r_inflight <= w_issue;
      r_ob_cnt   <= w_ob_cnt_nx;
      r_ob0      <= w_ob0_nx;
      r_ob1      <= w_ob1_nx;
      r_m_valid  <= (w_ob_cnt_nx != 2'd0);
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural dual-port RAM.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [5:0] count;
  logic       full;
  logic       empty;
  logic       ram_we_a;
  logic [3:0] ram_addr_a;
  logic [7:0] ram_din_a;
  logic       ram_we_b;
  logic [3:0] ram_addr_b;
  logic [7:0] ram_dout_b = '0;

  logic [7:0] mem [16];

  int n_tot = 0;
  int n_bad = 0;
  int acc, viol, sent, got, cyc;
  bit hold;
  logic [7:0] hold_d;
  logic [7:0] q [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  dpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .empty(empty),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_we_b(ram_we_b),
    .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    n_tot++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_we_a", ram_we_a, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("we_b_tied", ram_we_b, 0);
    nxt();
    rst_n = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    chk("rel_s_ready", s_ready, 1);
    nxt();

    // single word latency
    m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      s_valid = (c == 0);
      s_data  = 8'hA5;
      @(negedge clk);
      chk("lat_valid", m_valid, (c == 3));
      if (c == 3) chk("lat_data", m_data, 8'hA5);
      nxt();
    end
    @(negedge clk);
    chk("lat_count", count, 0);
    nxt();

    // fill with consumer stalled
    m_ready = 1'b0; acc = 0; viol = 0;
    for (int c = 0; c < 25; c++) begin
      s_valid = (acc < 20);
      s_data  = 8'(acc);
      @(negedge clk);
      if (ram_we_a && !s_ready) viol++;
      if (s_valid && s_ready) acc++;
      nxt();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("fill_acc", acc, 18);
    chk("fill_count", count, 18);
    chk("fill_full", full, 1);
    chk("fill_we_viol", viol, 0);
    nxt();

    // drain
    m_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("drain_valid", m_valid, 1);
      chk("drain_data", m_data, k);
      nxt();
    end
    @(negedge clk);
    chk("drain_empty", empty, 1);
    chk("drain_mv", m_valid, 0);
    nxt();

    // streaming 100 words
    for (int c = 0; c < 106; c++) begin
      s_valid = (c < 100);
      s_data  = 8'(c + 7);
      @(negedge clk);
      if (c < 100) chk("str_ready", s_ready, 1);
      chk("str_valid", m_valid, (c >= 3 && c < 103));
      if (c >= 3 && c < 103) chk("str_data", m_data, 8'(c + 4));
      nxt();
    end

    // random handshakes with scoreboard
    sent = 0; got = 0; cyc = 0; hold = 0;
    while (got < 50 && cyc < 3000) begin
      s_valid = (sent < 50) && ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom_range(0, 255));
      m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_d);
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        sent++;
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("sb_extra", 1, 0);
        else chk("sb_data", m_data, q.pop_front());
        got++;
      end
      hold   = m_valid && !m_ready;
      hold_d = m_data;
      cyc++;
      nxt();
    end
    chk("sb_got", got, 50);
    s_valid = 1'b0; m_ready = 1'b0;
    nxt();

    // reset mid-operation
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'hE0 + c);
      nxt();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("pre_count", count, 10);
    nxt();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_valid = (c == 0);
      s_data  = 8'h3C;
      @(negedge clk);
      if (c == 0) begin
        chk("mr_count", count, 0);
        chk("mr_s_ready", s_ready, 1);
      end
      chk("mr_valid", m_valid, (c == 3));
      if (c == 3) chk("mr_data", m_data, 8'h3C);
      nxt();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, RAM address width; DEPTH = 2^ADDR_WIDTH.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset.
REQ-004 Port list, continued: s_valid  input  1  write request; s_ready  output  1  write accept; s_data  input  DATA_WIDTH  write word.
REQ-005 Port list, continued: m_valid  output  1  read word available; m_ready  input  1  consumer accept; m_data  output  DATA_WIDTH  read word.
REQ-006 Port list, continued: count  output  ADDR_WIDTH+2  total words held; full  output  1  s_ready low; empty  output  1  count==0.
REQ-007 Port list, continued: ram_we_a  output  1; ram_addr_a  output  ADDR_WIDTH; ram_din_a  output  DATA_WIDTH.
REQ-008 Port list, continued: ram_we_b  output  1, tied 0; ram_addr_b  output  ADDR_WIDTH; ram_dout_b  input  DATA_WIDTH, 1-cycle registered read data from the attached dual-port RAM.
REQ-009 The block SHALL drive RAM port A (write) and port B (read only) from the single clock clk.

Function
REQ-010 Write accept SHALL occur in a cycle with s_valid && s_ready; that cycle ram_we_a=1, ram_addr_a=wr_ptr, ram_din_a=s_data; wr_ptr increments modulo DEPTH.
REQ-011 ram_we_a SHALL be 0 in every cycle without a write accept.
REQ-012 s_ready SHALL be 1 exactly when rst_n==1 and ram_cnt < DEPTH, where ram_cnt = words written but not yet read-issued; s_ready SHALL NOT depend on m_ready.
REQ-013 ram_addr_b SHALL equal rd_ptr every cycle.
REQ-014 A read issue SHALL occur when ram_cnt > 0 and (obuf_cnt + inflight - pop) < 2, where pop = m_valid && m_ready; on issue rd_ptr increments modulo DEPTH and inflight is set for the next cycle.
REQ-015 In the cycle after an issue, ram_dout_b SHALL be captured into a 2-entry in-order output buffer (obuf_cnt 0..2).
REQ-016 m_valid SHALL equal obuf_cnt > 0; m_data SHALL be the oldest buffered word; both are registered outputs.
REQ-017 A read issue in the same cycle as a write accept SHALL be suppressed when ram_cnt==0, so same-address read-during-write never occurs.
REQ-018 Simultaneous write accept and read issue SHALL leave ram_cnt unchanged.
REQ-019 First-word latency SHALL be exactly 3 cycles: accept in cycle N gives m_valid=1 in cycle N+3.
REQ-020 With s_valid and m_ready held high, sustained throughput SHALL be 1 word per cycle with no bubbles.
REQ-021 Total capacity SHALL be DEPTH+2; count = ram_cnt + inflight + obuf_cnt.
REQ-022 Data SHALL emerge in acceptance order, with no loss or duplication across pointer wrap-around.
REQ-023 m_valid, once high, SHALL hold and m_data SHALL remain stable until m_ready is sampled high.

Reset
REQ-024 While rst_n==0 at a rising edge: wr_ptr, rd_ptr, ram_cnt, inflight and obuf_cnt SHALL clear to 0, and any in-flight read SHALL be discarded.
REQ-025 Outputs during and immediately after reset SHALL be: m_valid=0, m_data=0, ram_we_a=0, count=0, empty=1, s_ready=0 while rst_n==0, and s_ready=1 in the first cycle with rst_n==1.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; no pre-reset word SHALL appear on m_data afterwards.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-027 Bench SHALL cover: after reset, one write of 0xA5 in cycle 0 with m_ready=1 -> m_valid=1, m_data=0xA5 in cycle 3 only; count returns to 0.
REQ-028 Bench SHALL cover: m_ready=0, s_valid held with data 0..19 -> exactly 18 accepted; count=18; full=1; ram_we_a never asserted while s_ready=0.
REQ-029 Bench SHALL cover: from that full state, m_ready=1 -> 0x00..0x11 on 18 consecutive cycles, then empty=1.
REQ-030 Bench SHALL cover: continuous streaming of 100 words with m_ready=1 -> m_valid contiguous from cycle 3, one word per cycle, in order.
REQ-031 Bench SHALL cover: 50 words with random s_valid and m_ready -> scoreboard exact match through at least 3 pointer wraps.
REQ-032 Bench SHALL cover: 10 words stored, rst_n low for 1 cycle -> count=0, m_valid=0, s_ready=1; next write 0x3C is the first word output.
